// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - sequential carry-propagate resolver for carry-save pairs
// Resolves sum + 2*carry CHUNK bits per cycle through a registered carry.
module csa_resolver #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_result
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  // Operands shift right one chunk per BUSY cycle, so the active chunk is always at bit 0.
  logic [WIDTH-1:0] a_q, b_q;
  logic             b_top_q;
  logic             c_q;
  logic [CW-1:0]    k_q;
  logic [WIDTH+1:0] res_q, res_nx;
  logic [CHUNK:0]   chunk_sum;
  logic [1:0]       top_sum;
  logic             accept, last;

  assign accept     = (state == IDLE) && in_valid;
  assign last       = (k_q == LAST);
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = res_q;

  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(c_q);
  assign top_sum   = {1'b0, b_top_q} + {1'b0, chunk_sum[CHUNK]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = BUSY;
      BUSY:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    res_nx = res_q;
    if (state == BUSY) begin
      for (int j = 0; j < NCHUNK; j++) begin
        if (k_q == CW'(j)) res_nx[j*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      end
      if (last) res_nx[WIDTH+1:WIDTH] = top_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      b_top_q <= 1'b0;
      c_q     <= 1'b0;
      k_q     <= '0;
      res_q   <= '0;
    end else begin
      res_q <= res_nx;
      if (accept) begin
        a_q     <= in_sum;
        b_q     <= WIDTH'({in_carry, 1'b0});
        b_top_q <= in_carry[WIDTH-1];
        c_q     <= 1'b0;
        k_q     <= '0;
      end else if (state == BUSY) begin
        a_q <= a_q >> CHUNK;
        b_q <= b_q >> CHUNK;
        c_q <= chunk_sum[CHUNK];
        k_q <= k_q + CW'(1);
      end
    end
  end

endmodule

// File: doc/csa_resolver.md
# csa_resolver

Sequential carry-propagate resolver for redundant carry-save operands. It accepts a (sum, carry) vector pair, as produced by the carry-save stage at the end of the Wallace tree, and returns the binary value sum + 2·carry. The add is done CHUNK bits per cycle through a registered carry, which keeps the final adder short in area and critical path. Valid/ready handshakes on both sides let it sit between the compressor tree and downstream accumulation logic.

## Interface
- WIDTH, 16: width of each redundant input vector; must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  sole clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands (high only in IDLE).
- in_sum  input  WIDTH  sum vector, bit i weight 2^i.
- in_carry  input  WIDTH  carry vector, bit i weight 2^(i+1).
- out_valid  output  1  out_result holds a completed result.
- out_ready  input  1  downstream accepts result.
- out_result  output  WIDTH+2  in_sum + 2·in_carry, zero-extended, exact (no overflow possible).

## Operation
- Internal operands: A = {2'b0, in_sum}, B = {1'b0, in_carry, 1'b0}, latched on accept; NCHUNK = WIDTH/CHUNK; chunk counter width max(1, clog2(NCHUNK)); carry register c.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid: latch A, B; clear c and the chunk index; go to BUSY.
- BUSY, chunk k = 0..NCHUNK-1: {c, out_result[k·CHUNK +: CHUNK]} ← A[k·CHUNK +: CHUNK] + B[k·CHUNK +: CHUNK] + c. On k = NCHUNK-1, also write out_result[WIDTH+1:WIDTH] ← B[WIDTH] + carry-out of that chunk (2-bit sum), then go to DONE. in_ready=0; in_valid is ignored.
- DONE: out_valid=1 and out_result is stable. On out_ready, go to IDLE. in_ready=0.
- out_result bits not yet written in the current transaction keep stale values; they are valid only while out_valid=1.
- CHUNK = WIDTH: BUSY lasts exactly one cycle. CHUNK = 1: bit-serial, WIDTH BUSY cycles.
- Reset (any state, including mid-BUSY or DONE): go to IDLE and drop the transaction; nothing is emitted for it.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0, c=0, chunk index 0.
- Accept edge E (in_valid & in_ready). out_valid rises after edge E+NCHUNK.
- Input-to-output latency is NCHUNK cycles.
- If out_ready is high when out_valid rises, the output handshake completes at edge E+NCHUNK+1. in_ready returns high after that edge, so the next accept is at edge E+NCHUNK+2 at the earliest. Peak throughput is 1 result per NCHUNK+2 cycles.
- out_valid is not combinationally dependent on out_ready. in_ready is a pure decode of state, with no path from in_valid.
- Backpressure: out_valid and out_result hold indefinitely while out_ready=0.
- in_sum and in_carry are sampled only on the accept edge; they may change afterwards.

## Test plan
- WIDTH=16, CHUNK=4; in_sum=0x00FF, in_carry=0x0001 -> out_result=0x00101; out_valid exactly 4 cycles after accept; in_ready=0 for those cycles.
- Maximum operands: in_sum=0xFFFF, in_carry=0xFFFF -> out_result=0x2FFFD, which checks that both top bits are written.
- Full-length ripple: in_sum=0xFFFF, in_carry=0x0001 -> out_result=0x10001, with the carry crossing all 4 chunk boundaries.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new data meanwhile -> out_result is unchanged, in_ready=0, the new data is ignored, and a single handshake occurs when out_ready=1.
- Reset mid-operation: assert rst_n=0 after 2 BUSY cycles -> out_valid=0 and in_ready=1 immediately, with no output for that transaction. Then in_sum=0x1234, in_carry=0x0102 -> out_result=0x01438.
- Random back-to-back traffic with random out_ready, run at CHUNK ∈ {1, 4, 16} -> every out_result equals in_sum + 2·in_carry, in order, with no drops or duplicates.
